// File: rtl/memory_reader.sv
`default_nettype none
// ============================================================================
// Module      : memory_reader
// Description : Read-side controller for the convolution line BRAM. It issues
//               sequential read addresses starting at a base address, hides
//               the one-cycle registered read latency of the BRAM, and
//               streams the returned words over a valid/ready handshake.
//               A 2-entry output buffer absorbs downstream backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_reader #(
  parameter int RAM_WIDTH  = 13,
  parameter int NB_ADDRESS = 10
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_N,
  input  logic                  i_start,
  input  logic [NB_ADDRESS-1:0] i_baseAdd,
  input  logic [NB_ADDRESS:0]   i_length,
  output logic [NB_ADDRESS-1:0] o_readAdd,
  input  logic [RAM_WIDTH-1:0]  i_memData,
  output logic [RAM_WIDTH-1:0]  o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [NB_ADDRESS-1:0] ADDR_STEP = NB_ADDRESS'(1);
  localparam logic [NB_ADDRESS:0]   LEN_ONE   = (NB_ADDRESS + 1)'(1);
  localparam logic [NB_ADDRESS:0]   LEN_ZERO  = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [NB_ADDRESS:0]   remaining;   // addresses still to issue
  logic                  inflight;    // a read was issued last cycle
  logic [1:0]            buf_count;   // occupied output buffer entries
  logic [RAM_WIDTH-1:0]  buf_head;    // oldest entry, drives o_data
  logic [RAM_WIDTH-1:0]  buf_tail;    // second entry

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            occupancy;   // entries held or owed after this cycle's pop

  assign o_data  = buf_head;
  assign o_valid = (buf_count != 2'd0);

  // Handshake and issue decision: a new read may only go out when the word
  // it returns is guaranteed a free buffer slot, counting the one in flight.
  always_comb begin
    pop       = o_valid & i_ready;
    push      = inflight;
    occupancy = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
    issue     = (state == READ) && (occupancy < 3'd2);
  end

  // Burst control FSM with registered address, busy and done outputs.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state     <= IDLE;
      o_readAdd <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      inflight <= issue;
      o_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (i_length != LEN_ZERO) begin
              state     <= READ;
              o_readAdd <= i_baseAdd;
              remaining <= i_length;
              o_busy    <= 1'b1;
            end else begin
              // Empty burst: acknowledge immediately without touching the BRAM.
              o_done <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            // Address wraps naturally at the BRAM depth.
            o_readAdd <= o_readAdd + ADDR_STEP;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Finish once the last word has left the buffer and nothing is owed.
          if (occupancy == 3'd0) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry FIFO kept as a head/tail shift pair so the head is o_data.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      buf_count <= 2'd0;
      buf_head  <= '0;
      buf_tail  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (buf_count == 2'd0) begin
            buf_head <= i_memData;
          end else begin
            buf_tail <= i_memData;
          end
          buf_count <= buf_count + 2'd1;
        end
        2'b01: begin
          // Head only changes when a second word is waiting behind it.
          if (buf_count == 2'd2) begin
            buf_head <= buf_tail;
          end
          buf_count <= buf_count - 2'd1;
        end
        2'b11: begin
          if (buf_count == 2'd1) begin
            buf_head <= i_memData;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= i_memData;
          end
        end
        default: begin
          buf_count <= buf_count;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_reader
// Description : Scoreboard bench for memory_reader with a BRAM model, a
//               randomizing ready driver and a decoupled output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_reader;

  localparam int RW    = 13;
  localparam int NA    = 10;
  localparam int DEPTH = 1 << NA;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          i_start  = 1'b0;
  logic          i_ready  = 1'b0;
  logic [NA-1:0] i_baseAdd = '0;
  logic [NA:0]   i_length  = '0;
  logic [RW-1:0] mem_data  = '0;
  logic [NA-1:0] o_readAdd;
  logic [RW-1:0] o_data;
  logic          o_valid;
  logic          o_busy;
  logic          o_done;

  logic [RW-1:0] mem [DEPTH];

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int beats     = 0;
  int done_seen = 0;
  int done_cyc  = -1;
  int ready_mode = 0;

  logic [RW-1:0] exp_q [$];
  int            beat_cyc [$];

  memory_reader #(.RAM_WIDTH(RW), .NB_ADDRESS(NA)) dut (
    .i_CLK     (clk),
    .i_RST_N   (rst_n),
    .i_start   (i_start),
    .i_baseAdd (i_baseAdd),
    .i_length  (i_length),
    .o_readAdd (o_readAdd),
    .i_memData (mem_data),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // BRAM with a one-cycle registered read
  always @(posedge clk) mem_data <= mem[o_readAdd];

  // Ready driver: 0 = always ready, 1 = random, 2 = 5-cycle stall at first valid
  int hold  = 0;
  bit armed = 1'b1;
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: i_ready = 1'b1;
        1: i_ready = ($urandom_range(0, 1) == 1);
        default: begin
          if (!o_busy) armed = 1'b1;
          if (armed && o_valid) begin
            hold  = 5;
            armed = 1'b0;
          end
          if (hold > 0) begin
            i_ready = 1'b0;
            hold--;
          end else begin
            i_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transferred beat
  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_data  = '0;
  logic [RW-1:0] exp_w;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(o_valid && o_data == prev_data)) begin
          errors++;
          $display("FAIL hold: valid=%0b data=%0d required valid=1 data=%0d", o_valid, o_data, prev_data);
        end
      end
      if (o_valid && i_ready) begin
        beats++;
        beat_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: data=%0d required no beat", o_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (o_data !== exp_w) begin
            errors++;
            $display("FAIL beat_data: got %0d required %0d (cycle %0d)", o_data, exp_w, cyc);
          end
        end
      end
      if (o_done) begin
        done_seen++;
        done_cyc = cyc;
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic start_burst(input int base, input int len, output int c);
    @(posedge clk); #1;
    i_start   = 1'b1;
    i_baseAdd = NA'(base);
    i_length  = (NA + 1)'(len);
    c = cyc;
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
    @(posedge clk); #1;
    i_start   = 1'b0;
    i_baseAdd = NA'($urandom);
    i_length  = (NA + 1)'($urandom);
  endtask

  task automatic finish_burst(input int prev, input int budget, input string name);
    int n = 0;
    while (done_seen == prev && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (done_seen == prev) begin
      errors++;
      $display("FAIL %s_timeout: no done after %0d cycles", name, budget);
    end
    repeat (3) @(negedge clk);
    #1;
    check({name, "_done_count"}, done_seen, prev + 1);
    check({name, "_leftover"}, exp_q.size(), 0);
    check({name, "_busy_after"}, int'(o_busy), 0);
  endtask

  int c, prev, b0, bc, n;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = RW'(i + 100);
    ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(o_valid), 0);
    check("rst_data", int'(o_data), 0);
    check("rst_readAdd", int'(o_readAdd), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic burst with exact timing
    prev = done_seen;
    b0 = beat_cyc.size();
    start_burst(0, 4, c);
    check("t1_busy", int'(o_busy), 1);
    check("t1_addr", int'(o_readAdd), 0);
    finish_burst(prev, 40, "t1");
    check("t1_nbeats", beat_cyc.size() - b0, 4);
    for (int k = 0; k < 4; k++) check("t1_beat_cycle", beat_cyc[b0 + k], c + 3 + k);
    check("t1_done_cycle", done_cyc, c + 7);

    // Address wrap
    prev = done_seen;
    start_burst(1022, 4, c);
    finish_burst(prev, 40, "wrap");

    // Backpressure
    ready_mode = 2;
    prev = done_seen;
    bc = beats;
    start_burst(50, 6, c);
    finish_burst(prev, 60, "bp");
    check("bp_beats", beats - bc, 6);
    ready_mode = 0;

    // Full-depth burst with random ready and random contents
    for (int i = 0; i < DEPTH; i++) mem[i] = RW'($urandom);
    ready_mode = 1;
    prev = done_seen;
    bc = beats;
    start_burst(int'($urandom_range(0, DEPTH - 1)), DEPTH, c);
    finish_burst(prev, 8000, "full");
    check("full_beats", beats - bc, DEPTH);

    // Zero length
    ready_mode = 0;
    prev = done_seen;
    bc = beats;
    start_burst(77, 0, c);
    finish_burst(prev, 10, "zero");
    check("zero_done_cycle", done_cyc, c + 1);
    check("zero_beats", beats - bc, 0);

    // Start while busy is ignored
    ready_mode = 1;
    prev = done_seen;
    start_burst(300, 6, c);
    @(posedge clk); #1;
    i_start = 1'b1; i_baseAdd = NA'(7); i_length = (NA + 1)'(3);
    @(posedge clk); #1;
    i_start = 1'b0;
    finish_burst(prev, 80, "busy_start");

    // Random bursts
    for (int r = 0; r < 6; r++) begin
      prev = done_seen;
      start_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), c);
      finish_burst(prev, 300, "rand");
    end

    // Reset in the middle of a burst
    ready_mode = 0;
    prev = done_seen;
    bc = beats;
    start_burst(200, 8, c);
    n = 0;
    while (beats < bc + 2 && n < 30) begin
      @(negedge clk); #1;
      n++;
    end
    check("mid_two_beats", beats - bc, 2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(o_valid), 0);
    check("mid_rst_data", int'(o_data), 0);
    check("mid_rst_readAdd", int'(o_readAdd), 0);
    check("mid_rst_busy", int'(o_busy), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    check("mid_no_done", done_seen, prev);
    check("mid_no_more_beats", beats - bc, 2);
    prev = done_seen;
    start_burst(5, 5, c);
    finish_burst(prev, 40, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
